// File: rtl/insn_fetch.sv
// insn_fetch -- opcode fetch sequencer with reset/NMI/IRQ opcode injection.
//
// Tracks whether the decoder is executing an instruction (EXEC) or the bus
// is in an opcode-fetch cycle (FETCH). On a fetch the opcode is taken
// from the data bus, or replaced by BRK_OPCODE when an interrupt is
// being serviced. Reset also injects BRK_OPCODE, so the decoder runs the
// reset sequence as an ordinary instruction.
//
// Optional feature macro: INSN_FETCH_INT_INJECT_EN
//   defined   -> NMI (falling-edge, latched) and IRQ (level, maskable by
//                i_flag) are detected and injected at fetch time.
//   undefined -> nmi/irq/i_flag are ignored, nmi_pending is tied low and
//                every fetch captures data_in.
//
// Ports
//   clk            in   clock, all state changes on rising edge
//   rst            in   synchronous active-high reset
//   data_in[7:0]   in   data-bus read value (opcode during fetch)
//   rdy            in   1 = advance, 0 = stall
//   sync_req       in   decoder's last micro-step; next cycle fetches
//   nmi            in   non-maskable interrupt, active-low, edge
//   irq            in   maskable interrupt, active-low, level
//   i_flag         in   interrupt-disable flag from the PSR
//   insn[7:0]      out  opcode presented to the decoder
//   sync           out  high during the opcode-fetch cycle
//   int_kind[1:0]  out  00 none/BRK, 01 IRQ, 10 NMI, 11 RESET
//   pc_inc_inhibit out  high while an injected opcode executes
//   nmi_pending    out  NMI edge seen, not yet serviced

module insn_fetch #(
  parameter logic [7:0] BRK_OPCODE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       rdy,
  input  logic       sync_req,
  input  logic       nmi,
  input  logic       irq,
  input  logic       i_flag,
  output logic [7:0] insn,
  output logic       sync,
  output logic [1:0] int_kind,
  output logic       pc_inc_inhibit,
  output logic       nmi_pending
);

  typedef enum logic {EXEC = 1'b0, FETCH = 1'b1} state_t;

  localparam logic [1:0] KIND_NONE  = 2'b00;
  localparam logic [1:0] KIND_IRQ   = 2'b01;
  localparam logic [1:0] KIND_NMI   = 2'b10;
  localparam logic [1:0] KIND_RESET = 2'b11;

  state_t     state_reg, state_next;
  logic       sync_reg;
  logic [7:0] insn_reg;
  logic [1:0] int_kind_reg;
  logic       pc_inc_inhibit_reg;
  logic       nmi_pending_reg;
  logic       capture;
  logic       take_nmi;
  logic       take_irq;

  // State register. sync is registered from the next state so it is
  // high for exactly the cycles the FSM sits in FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EXEC;
      sync_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sync_reg  <= (state_next == FETCH);
    end
  end

  // Next-state logic: rdy low freezes sequencing in either state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EXEC:    if (sync_req && rdy) state_next = FETCH;
      FETCH:   if (rdy)             state_next = EXEC;
      default: state_next = EXEC;
    endcase
  end

  assign capture = (state_reg == FETCH) && rdy;

`ifdef INSN_FETCH_INT_INJECT_EN
  logic nmi_prev_reg;
  logic nmi_fall;

  assign nmi_fall = nmi_prev_reg && !nmi;
  assign take_nmi = nmi_pending_reg;
  // IRQ is level-sampled in the fetch cycle only; nothing is latched.
  assign take_irq = !irq && !i_flag;

  // Edge detector runs regardless of rdy. A fresh edge arriving in the
  // same cycle an NMI is serviced keeps the pending bit set, queueing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_prev_reg    <= 1'b1;
      nmi_pending_reg <= 1'b0;
    end else begin
      nmi_prev_reg    <= nmi;
      nmi_pending_reg <= nmi_fall || (nmi_pending_reg && !(capture && take_nmi));
    end
  end
`else
  logic unused_int_inputs;

  assign unused_int_inputs = nmi ^ irq ^ i_flag;
  assign take_nmi          = 1'b0;
  assign take_irq          = 1'b0;

  always_ff @(posedge clk) begin
    nmi_pending_reg <= 1'b0;
  end
`endif

  // Opcode capture. Interrupt priority is NMI over IRQ over memory; a BRK
  // opcode fetched from memory still reports KIND_NONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      insn_reg           <= BRK_OPCODE;
      int_kind_reg       <= KIND_RESET;
      pc_inc_inhibit_reg <= 1'b1;
    end else if (capture) begin
      if (take_nmi) begin
        insn_reg           <= BRK_OPCODE;
        int_kind_reg       <= KIND_NMI;
        pc_inc_inhibit_reg <= 1'b1;
      end else if (take_irq) begin
        insn_reg           <= BRK_OPCODE;
        int_kind_reg       <= KIND_IRQ;
        pc_inc_inhibit_reg <= 1'b1;
      end else begin
        insn_reg           <= data_in;
        int_kind_reg       <= KIND_NONE;
        pc_inc_inhibit_reg <= 1'b0;
      end
    end
  end

  // Output logic.
  always_comb begin
    insn           = insn_reg;
    sync           = sync_reg;
    int_kind       = int_kind_reg;
    pc_inc_inhibit = pc_inc_inhibit_reg;
    nmi_pending    = nmi_pending_reg;
  end

endmodule

// File: doc/insn_fetch.md
INSN_FETCH -- requirements
Module: insn_fetch

Interface
REQ-001 Parameter BRK_OPCODE, default 8'h00: opcode injected for reset/NMI/IRQ sequences.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 data_in  input  8  data-bus read value; holds opcode during fetch cycle.
REQ-005 rdy  input  1  high = advance; low = stall sequencing.
REQ-006 sync_req  input  1  decoder last micro-step; next cycle is an opcode fetch.
REQ-007 nmi  input  1  non-maskable interrupt pin, active-low, edge-sensitive.
REQ-008 irq  input  1  maskable interrupt pin, active-low, level-sensitive.
REQ-009 i_flag  input  1  PSR interrupt-disable bit.
REQ-010 insn  output  8  opcode presented to decoder.
REQ-011 sync  output  1  high during opcode-fetch cycle.
REQ-012 int_kind  output  2  vector select: 00 none/BRK, 01 IRQ, 10 NMI, 11 RESET.
REQ-013 pc_inc_inhibit  output  1  high while an injected opcode executes; PC not incremented.
REQ-014 nmi_pending  output  1  NMI edge latched, not yet serviced.

Function
REQ-015 Two states: EXEC (decoder stepping insn) and FETCH (sync=1, opcode capture).
REQ-016 EXEC -> FETCH on rising edge when sync_req=1 and rdy=1; otherwise stay EXEC.
REQ-017 FETCH with rdy=1: capture, priority NMI > IRQ > memory; go EXEC next cycle.
REQ-018 Capture NMI (nmi_pending=1): insn<=BRK_OPCODE, int_kind<=10, pc_inc_inhibit<=1, nmi_pending cleared.
REQ-019 Capture IRQ (irq=0 and i_flag=0 sampled in the FETCH cycle): insn<=BRK_OPCODE, int_kind<=01, pc_inc_inhibit<=1.
REQ-020 Capture memory: insn<=data_in, int_kind<=00, pc_inc_inhibit<=0; data_in=BRK_OPCODE still reports 00.
REQ-021 FETCH with rdy=0: remain FETCH, sync held 1, insn/int_kind/pc_inc_inhibit unchanged.
REQ-022 sync is registered; equals 1 exactly in FETCH, 0 in EXEC.
REQ-023 NMI edge detector runs every cycle regardless of rdy: nmi_prev<=nmi; nmi_prev=1 and nmi=0 sets nmi_pending.
REQ-024 nmi held low sets nmi_pending once only; a new edge needs nmi high for at least one cycle.
REQ-025 New NMI edge in the same cycle as NMI capture: nmi_pending stays 1 (second NMI queued).
REQ-026 IRQ is not latched; irq deasserted before the FETCH cycle is not serviced.
REQ-027 i_flag changes take effect on the next FETCH; EXEC never aborts for interrupts.

Reset
REQ-028 rst=1 at any rising edge, including mid-EXEC or mid-FETCH: insn<=BRK_OPCODE, int_kind<=11, pc_inc_inhibit<=1, sync<=0, nmi_pending<=0, nmi_prev<=1, state<=EXEC.
REQ-029 rst overrides rdy, sync_req and all interrupt inputs in that cycle.
REQ-030 First cycle after rst deasserts: decoder executes reset sequence as EXEC of injected opcode; no fetch until sync_req.

Configuration
REQ-031 Macro INSN_FETCH_INT_INJECT_EN defined: NMI/IRQ detection and injection per REQ-018..REQ-027.
REQ-032 Macro undefined: nmi/irq/i_flag ignored; nmi_pending tied 0; FETCH always captures data_in; int_kind only 00 or 11; reset injection unchanged.

Verification
REQ-033 rst=1 one cycle mid-FETCH, data_in=8'hA9 -> next cycle insn=8'h00, int_kind=11, pc_inc_inhibit=1, sync=0, nmi_pending=0.
REQ-034 sync_req=1,rdy=1 then FETCH with data_in=8'hA9 -> sync=1 one cycle, then insn=8'hA9, int_kind=00, pc_inc_inhibit=0, sync=0.
REQ-035 FETCH with rdy=0 for 3 cycles, data_in toggling -> sync=1 all 3 cycles, insn unchanged; rdy=1 captures data_in of that cycle.
REQ-036 nmi 1->0 during EXEC, irq=0, i_flag=0 -> nmi_pending=1; next FETCH insn=8'h00, int_kind=10, nmi_pending=0; following FETCH int_kind=01.
REQ-037 irq=0, i_flag=1 through FETCH, data_in=8'hEA -> insn=8'hEA, int_kind=00; with macro undefined, nmi falling edge -> nmi_pending stays 0, capture from data_in.
